// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcodes, bus constants, FSM states and opcode decode for the data-RAM requester.
package data_mem_ctrl_pkg;

  localparam logic [3:0] MEM_OP_LB  = 4'h0;
  localparam logic [3:0] MEM_OP_LBU = 4'h1;
  localparam logic [3:0] MEM_OP_LH  = 4'h2;
  localparam logic [3:0] MEM_OP_LHU = 4'h3;
  localparam logic [3:0] MEM_OP_LW  = 4'h4;
  localparam logic [3:0] MEM_OP_SB  = 4'h5;
  localparam logic [3:0] MEM_OP_SH  = 4'h6;
  localparam logic [3:0] MEM_OP_SW  = 4'h7;
  localparam logic [3:0] MEM_OP_LL  = 4'h8;
  localparam logic [3:0] MEM_OP_SC  = 4'h9;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  typedef struct packed {
    size_e size;
    logic  sign_ext;
    logic  is_store;
    logic  is_llsc;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [3:0] op);
    op_info_t info;
    info.size     = SZ_NONE;
    info.sign_ext = 1'b0;
    info.is_store = 1'b0;
    info.is_llsc  = 1'b0;
    case (op)
      MEM_OP_LB:  begin info.size = SZ_BYTE; info.sign_ext = 1'b1; end
      MEM_OP_LBU: info.size = SZ_BYTE;
      MEM_OP_LH:  begin info.size = SZ_HALF; info.sign_ext = 1'b1; end
      MEM_OP_LHU: info.size = SZ_HALF;
      MEM_OP_LW:  info.size = SZ_WORD;
      MEM_OP_SB:  begin info.size = SZ_BYTE; info.is_store = 1'b1; end
      MEM_OP_SH:  begin info.size = SZ_HALF; info.is_store = 1'b1; end
      MEM_OP_SW:  begin info.size = SZ_WORD; info.is_store = 1'b1; end
      MEM_OP_LL:  begin info.size = SZ_WORD; info.is_llsc = 1'b1; end
      MEM_OP_SC:  begin info.size = SZ_WORD; info.is_store = 1'b1; info.is_llsc = 1'b1; end
      default:    info.size = SZ_NONE;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// Big-endian lane steering: byte-lane selects, alignment check, store replication
// and load extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  sel_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic        is_store_o,
  output logic        is_llsc_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  op_info_t   info;
  logic [7:0]  byte_raw;
  logic [15:0] half_raw;

  always_comb begin
    info         = decode_op(op_i);
    sel_o        = 4'b0000;
    misalign_o   = 1'b0;
    illegal_o    = (info.size == SZ_NONE);
    is_store_o   = info.is_store;
    is_llsc_o    = info.is_llsc;
    store_data_o = ZERO_WORD;
    load_data_o  = ZERO_WORD;

    // offset 0 is the most significant byte
    case (off_i)
      2'd0:    byte_raw = rdata_raw_i[31:24];
      2'd1:    byte_raw = rdata_raw_i[23:16];
      2'd2:    byte_raw = rdata_raw_i[15:8];
      default: byte_raw = rdata_raw_i[7:0];
    endcase
    half_raw = off_i[1] ? rdata_raw_i[15:0] : rdata_raw_i[31:16];

    case (info.size)
      SZ_BYTE: begin
        sel_o        = 4'b1000 >> off_i;
        store_data_o = {4{wdata_i[7:0]}};
        load_data_o  = {{24{info.sign_ext & byte_raw[7]}}, byte_raw};
      end
      SZ_HALF: begin
        sel_o        = off_i[1] ? 4'b0011 : 4'b1100;
        misalign_o   = off_i[0];
        store_data_o = {2{wdata_i[15:0]}};
        load_data_o  = {{16{info.sign_ext & half_raw[15]}}, half_raw};
      end
      SZ_WORD: begin
        sel_o        = 4'b1111;
        misalign_o   = (off_i != 2'b00);
        store_data_o = wdata_i;
        load_data_o  = rdata_raw_i;
      end
      default: begin
        sel_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-RAM requester: one load/store per handshake, 3-cycle turnaround.
// Build option LLSC_EN adds LL/SC ops, flush_i and llbit_o.
//
//   state     | meaning
//   ST_IDLE   | ready; latch request when req_valid_i
//   ST_ACCESS | single RAM cycle; store commits / load captured at its end
//   ST_DONE   | one-cycle response pulse
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              stall_req_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
`ifdef LLSC_EN
  ,
  input  logic              flush_i,
  output logic              llbit_o
`endif
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [3:0]        align_op;
  logic [1:0]        align_off;
  logic [3:0]        lane_sel;
  logic              lane_misalign;
  logic              lane_illegal;
  logic              lane_is_store;
  logic              lane_is_llsc;
  logic [31:0]       lane_store_data;
  logic [31:0]       lane_load_data;
  logic              bad_req;
  logic              sc_fail;

  // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
  assign align_op  = (state_q == ST_IDLE) ? req_op_i        : op_q;
  assign align_off = (state_q == ST_IDLE) ? req_addr_i[1:0] : addr_q[1:0];

  mem_lane_align u_lane_align (
    .op_i         (align_op),
    .off_i        (align_off),
    .wdata_i      (wdata_q),
    .rdata_raw_i  (mem_data_i),
    .sel_o        (lane_sel),
    .misalign_o   (lane_misalign),
    .illegal_o    (lane_illegal),
    .is_store_o   (lane_is_store),
    .is_llsc_o    (lane_is_llsc),
    .store_data_o (lane_store_data),
    .load_data_o  (lane_load_data)
  );

`ifdef LLSC_EN
  logic llbit_q, llbit_d;

  assign bad_req = lane_misalign | lane_illegal;
  assign sc_fail = (req_op_i == MEM_OP_SC) & ~llbit_q;
  assign llbit_o = llbit_q;

  // flush wins over an LL completing in the same cycle
  always_comb begin
    llbit_d = llbit_q;
    if (state_q == ST_DONE && !err_q) begin
      if (op_q == MEM_OP_LL) begin
        llbit_d = 1'b1;
      end else if (op_q == MEM_OP_SC) begin
        llbit_d = 1'b0;
      end
    end
    if (flush_i) begin
      llbit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      llbit_q <= 1'b0;
    end else begin
      llbit_q <= llbit_d;
    end
  end
`else
  assign bad_req = lane_misalign | lane_illegal | lane_is_llsc;
  assign sc_fail = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    stall_req_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = ZERO_WORD;
    resp_err_o   = 1'b0;
    mem_ce_o     = CHIP_DISABLE;
    mem_we_o     = WRITE_DISABLE;
    mem_addr_o   = '0;
    mem_sel_o    = 4'b0000;
    mem_data_o   = ZERO_WORD;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        stall_req_o = req_valid_i;
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = ZERO_WORD;
          err_d   = bad_req;
          state_d = (bad_req || sc_fail) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall_req_o = 1'b1;
        // rst low here blocks the write at the same edge that resets the FSM
        mem_ce_o    = rst;
        mem_we_o    = lane_is_store ? WRITE_ENABLE : WRITE_DISABLE;
        mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_sel_o   = lane_sel;
        mem_data_o  = lane_store_data;
        if (lane_is_store) begin
          rdata_d = lane_is_llsc ? 32'h0000_0001 : ZERO_WORD;
        end else begin
          rdata_d = lane_load_data;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
